// File: rtl/axi_ram_bist.sv
// AXI4 RAM fill/self-test sequencer: writes seed+beat_index in fixed INCR bursts,
// optionally reads the region back, counting errors and logging the first failing beat.
module axi_ram_bist #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 8,
  parameter int AXI_ID     = 0,
  parameter int BURST_LEN  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  check_en,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [15:0]           burst_count,
  input  logic [DATA_WIDTH-1:0] seed,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           err_count,
  output logic [ADDR_WIDTH-1:0] first_err_addr,
  output logic [ID_WIDTH-1:0]   m_axi_awid,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic                  m_axi_awlock,
  output logic [3:0]            m_axi_awcache,
  output logic [2:0]            m_axi_awprot,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic [STRB_WIDTH-1:0] m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [ID_WIDTH-1:0]   m_axi_bid,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arlock,
  output logic [3:0]            m_axi_arcache,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [ID_WIDTH-1:0]   m_axi_rid,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  localparam int LOC_W     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int SIZE_LOG2 = $clog2(STRB_WIDTH);
  localparam logic [LOC_W-1:0]      LAST_BEAT   = LOC_W'(BURST_LEN - 1);
  localparam logic [ADDR_WIDTH-1:0] BURST_BYTES = ADDR_WIDTH'(BURST_LEN * STRB_WIDTH);

  typedef enum logic [2:0] {IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE} state_t;
  state_t state, state_d;

  logic [ADDR_WIDTH-1:0] base_q, addr, beat_addr, err_addr;
  logic [15:0]           count_q, bursts_left;
  logic [DATA_WIDTH-1:0] seed_q, beat_idx, pattern;
  logic [LOC_W-1:0]      beat;
  logic                  check_q, beat_last, last_burst, err_evt;
  logic                  unused_ids;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign m_axi_awid    = ID_WIDTH'(AXI_ID);
  assign m_axi_awaddr  = addr;
  assign m_axi_awlen   = 8'(BURST_LEN - 1);
  assign m_axi_awsize  = 3'(SIZE_LOG2);
  assign m_axi_awburst = 2'b01;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = 4'b0011;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_arid    = ID_WIDTH'(AXI_ID);
  assign m_axi_araddr  = addr;
  assign m_axi_arlen   = 8'(BURST_LEN - 1);
  assign m_axi_arsize  = 3'(SIZE_LOG2);
  assign m_axi_arburst = 2'b01;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = 4'b0011;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_wstrb   = '1;
  assign m_axi_wdata   = pattern;
  assign m_axi_wlast   = (state == WR_DATA) && beat_last;

  assign pattern    = seed_q + beat_idx;
  assign beat_last  = (beat == LAST_BEAT);
  assign last_burst = (bursts_left == 16'd1);
  assign beat_addr  = addr + (ADDR_WIDTH'(beat) << SIZE_LOG2);
  // Responses carry no information we need: this block is the only ID source.
  assign unused_ids = ^{m_axi_bid, m_axi_rid};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d       = state;
    busy          = 1'b1;
    done          = 1'b0;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_bready  = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_d = (burst_count == 16'd0) ? DONE : WR_ADDR;
      end
      WR_ADDR: begin
        m_axi_awvalid = 1'b1;
        if (m_axi_awready) state_d = WR_DATA;
      end
      WR_DATA: begin
        m_axi_wvalid = 1'b1;
        if (m_axi_wready && beat_last) state_d = WR_RESP;
      end
      WR_RESP: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) begin
          if (!last_burst)  state_d = WR_ADDR;
          else if (check_q) state_d = RD_ADDR;
          else              state_d = DONE;
        end
      end
      RD_ADDR: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) state_d = RD_DATA;
      end
      RD_DATA: begin
        m_axi_rready = 1'b1;
        if (m_axi_rvalid && beat_last) state_d = last_burst ? DONE : RD_ADDR;
      end
      DONE: begin
        busy    = 1'b0;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Run counters are reloaded on every accepted start, so they need no reset.
  always_ff @(posedge clk) begin
    case (state)
      IDLE: if (start) begin
        base_q      <= base_addr;
        addr        <= base_addr;
        count_q     <= burst_count;
        bursts_left <= burst_count;
        seed_q      <= seed;
        check_q     <= check_en;
        beat_idx    <= '0;
        beat        <= '0;
      end
      WR_DATA: if (m_axi_wready) begin
        beat_idx <= beat_idx + 1'b1;
        beat     <= beat_last ? '0 : beat + 1'b1;
      end
      WR_RESP: if (m_axi_bvalid) begin
        if (last_burst) begin
          addr        <= base_q;
          bursts_left <= count_q;
          beat_idx    <= '0;
        end else begin
          addr        <= addr + BURST_BYTES;
          bursts_left <= bursts_left - 16'd1;
        end
      end
      RD_DATA: if (m_axi_rvalid) begin
        beat_idx <= beat_idx + 1'b1;
        beat     <= beat_last ? '0 : beat + 1'b1;
        if (beat_last) begin
          addr        <= addr + BURST_BYTES;
          bursts_left <= bursts_left - 16'd1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    err_evt  = 1'b0;
    err_addr = addr;
    if (state == WR_RESP && m_axi_bvalid && m_axi_bresp != 2'b00) err_evt = 1'b1;
    if (state == RD_DATA && m_axi_rvalid) begin
      err_addr = beat_addr;
      if (m_axi_rdata != pattern || m_axi_rresp != 2'b00 || m_axi_rlast != beat_last)
        err_evt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_count      <= '0;
      first_err_addr <= '0;
    end else if (state == IDLE && start) begin
      err_count      <= '0;
      first_err_addr <= '0;
    end else if (err_evt) begin
      if (err_count == 16'd0) first_err_addr <= err_addr;
      err_count <= sat_inc(err_count);
    end
  end

endmodule
